// File: rtl/pipe_ctrl_regs_pkg.sv
// Shared types and constants for the ID->X->WB control-metadata pipeline:
// opcode constants, controller state encodings and stage slot layouts.
package pipe_ctrl_regs_pkg;

  localparam logic [6:0] OPC_BUBBLE = 7'd0;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [0:0] {
    PC_RUN   = 1'b0,
    PC_FLUSH = 1'b1
  } pc_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rf_wen;
    logic [6:0] opcode;
  } x_slot_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rf_wen;
    logic [6:0] opcode;
  } wb_slot_t;

  // x0 is hard-wired, so a write to it is never a real RF write.
  function automatic logic wen_qual(input logic wen, input logic [4:0] rd);
    return wen & (rd != 5'd0);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: async reset, hold when en=0,
// synchronous clear to an all-zero bubble when en=1 and clr=1.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Stage storage: capture, bubble-clear or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {W{1'b0}};
    end else if (en) begin
      if (clr) begin
        q_r <= {W{1'b0}};
      end else begin
        q_r <= d;
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Control-metadata pipeline ID->X->WB with stall hold, post-redirect ID kill
// and a retired-instruction counter; feeds the forwarding unit's X/WB inputs.
module pipe_ctrl_regs
  import pipe_ctrl_regs_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rf_wen,
  input  logic [6:0]       id_opcode,
  input  logic             x_redirect,
  input  logic             stall_req,
  output logic             x_valid,
  output logic [4:0]       rd_X,
  output logic [4:0]       rs1_X,
  output logic [4:0]       rs2_X,
  output logic             rf_wen_X,
  output logic             wb_valid,
  output logic [4:0]       rd_WB,
  output logic             rf_wen_WB,
  output logic [6:0]       opcode_WB,
  output logic             stall_pc,
  output logic             kill_ID,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  pc_state_t        state_r, state_nxt_s;
  logic [2:0]       cnt_r, cnt_nxt_s;
  logic             advance_s;
  logic             redir_s;
  logic             kill_s;
  x_slot_t          x_d_s, x_slot_r;
  wb_slot_t         wb_d_s, wb_slot_r;
  logic [CNT_W-1:0] instret_r;

  assign advance_s = ~stall_req;
  // A stalled redirect is not consumed: X holds it and it is seen again on advance.
  assign redir_s   = x_redirect & x_slot_r.valid & advance_s;

  // Flush controller state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= PC_RUN;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Flush controller next state and ID kill.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    kill_s      = 1'b0;
    case (state_r)
      PC_RUN: begin
        if (redir_s) begin
          kill_s = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt_s = PC_FLUSH;
            cnt_nxt_s   = FLUSH_LOAD;
          end else begin
            state_nxt_s = PC_RUN;
          end
        end else begin
          state_nxt_s = PC_RUN;
        end
      end
      PC_FLUSH: begin
        // X holds a bubble here, so any redirect is spurious and ignored.
        kill_s = 1'b1;
        if (advance_s) begin
          if (cnt_r <= 3'd1) begin
            state_nxt_s = PC_RUN;
            cnt_nxt_s   = 3'd0;
          end else begin
            cnt_nxt_s = cnt_r - 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = PC_RUN;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // ID fields heading into X, with rf_wen already qualified against x0.
  always_comb begin
    x_d_s        = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, OPC_BUBBLE};
    x_d_s.valid  = id_valid & ~kill_s;
    x_d_s.rd     = id_rd;
    x_d_s.rs1    = id_rs1;
    x_d_s.rs2    = id_rs2;
    x_d_s.rf_wen = wen_qual(id_rf_wen, id_rd);
    x_d_s.opcode = id_opcode;
  end

  // X fields heading into WB.
  always_comb begin
    wb_d_s        = '{1'b0, 5'd0, 1'b0, OPC_BUBBLE};
    wb_d_s.valid  = x_slot_r.valid;
    wb_d_s.rd     = x_slot_r.rd;
    wb_d_s.rf_wen = x_slot_r.rf_wen;
    wb_d_s.opcode = x_slot_r.opcode;
  end

  pipe_stage_reg #(.W($bits(x_slot_t))) u_x_stage (
    .clk (clk),
    .rst (rst),
    .en  (advance_s),
    .clr (~x_d_s.valid),
    .d   (x_d_s),
    .q   (x_slot_r)
  );

  pipe_stage_reg #(.W($bits(wb_slot_t))) u_wb_stage (
    .clk (clk),
    .rst (rst),
    .en  (advance_s),
    .clr (~wb_d_s.valid),
    .d   (wb_d_s),
    .q   (wb_slot_r)
  );

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_r <= {CNT_W{1'b0}};
    end else if (wb_slot_r.valid & advance_s) begin
      instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_r <= instret_r;
    end
  end

  assign x_valid   = x_slot_r.valid;
  assign rd_X      = x_slot_r.rd;
  assign rs1_X     = x_slot_r.rs1;
  assign rs2_X     = x_slot_r.rs2;
  assign rf_wen_X  = x_slot_r.rf_wen & x_slot_r.valid;
  assign wb_valid  = wb_slot_r.valid;
  assign rd_WB     = wb_slot_r.rd;
  assign rf_wen_WB = wb_slot_r.rf_wen & wb_slot_r.valid;
  assign opcode_WB = wb_slot_r.opcode;
  assign stall_pc  = stall_req;
  assign kill_ID   = kill_s;
  assign instret   = instret_r;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Scoreboard bench for pipe_ctrl_regs: expected X/WB slots are queued as
// stimulus is applied and compared against the DUT every cycle.
module tb_pipe_ctrl_regs;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rd, id_rs1, id_rs2;
  logic             id_rf_wen;
  logic [6:0]       id_opcode;
  logic             x_redirect;
  logic             stall_req;
  logic             x_valid;
  logic [4:0]       rd_X, rs1_X, rs2_X;
  logic             rf_wen_X;
  logic             wb_valid;
  logic [4:0]       rd_WB;
  logic             rf_wen_WB;
  logic [6:0]       opcode_WB;
  logic             stall_pc;
  logic             kill_ID;
  logic [CNT_W-1:0] instret;

  pipe_ctrl_regs #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rf_wen(id_rf_wen), .id_opcode(id_opcode),
    .x_redirect(x_redirect), .stall_req(stall_req),
    .x_valid(x_valid), .rd_X(rd_X), .rs1_X(rs1_X), .rs2_X(rs2_X), .rf_wen_X(rf_wen_X),
    .wb_valid(wb_valid), .rd_WB(rd_WB), .rf_wen_WB(rf_wen_WB), .opcode_WB(opcode_WB),
    .stall_pc(stall_pc), .kill_ID(kill_ID), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       wen;
    bit [6:0] opc;
  } rec_t;

  // exp_q[0] is the expected WB slot, exp_q[1] the expected X slot.
  rec_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          flush_left;
  logic [31:0] exp_instret;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    rec_t b;
    b = '{default: 0};
    exp_q.delete();
    exp_q.push_back(b);
    exp_q.push_back(b);
    flush_left  = 0;
    exp_instret = 32'd0;
  endtask

  task automatic step(input bit v, input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                      input bit wen, input bit [6:0] opc, input bit redir, input bit stall);
    rec_t xe, we, nx;
    bit   mr, ek;
    id_valid   = v;
    id_rd      = rd;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_rf_wen  = wen;
    id_opcode  = opc;
    x_redirect = redir;
    stall_req  = stall;
    @(negedge clk);
    xe = exp_q[1];
    we = exp_q[0];
    mr = redir && xe.valid && !stall;
    ek = (flush_left > 0) || mr;
    check("kill_ID", 64'(kill_ID), 64'(ek));
    check("stall_pc", 64'(stall_pc), 64'(stall));
    check("x_slot", 64'({x_valid, rd_X, rs1_X, rs2_X, rf_wen_X}),
          64'({xe.valid, xe.rd, xe.rs1, xe.rs2, xe.wen}));
    check("wb_slot", 64'({wb_valid, rd_WB, rf_wen_WB, opcode_WB}),
          64'({we.valid, we.rd, we.wen, we.opc}));
    check("instret", 64'(instret), 64'(exp_instret));
    @(posedge clk);
    if (!stall) begin
      if (we.valid) exp_instret = exp_instret + 32'd1;
      nx = '{default: 0};
      if (v && !ek) begin
        nx.valid = 1'b1;
        nx.rd    = rd;
        nx.rs1   = rs1;
        nx.rs2   = rs2;
        nx.wen   = wen && (rd != 5'd0);
        nx.opc   = opc;
      end
      exp_q.push_back(nx);
      void'(exp_q.pop_front());
      if (flush_left > 0) flush_left = flush_left - 1;
      else if (mr) flush_left = FLUSH_CYCLES - 1;
    end
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({x_valid, rd_X, rs1_X, rs2_X, rf_wen_X, wb_valid, rd_WB, rf_wen_WB,
                    opcode_WB, stall_pc, kill_ID}), 64'd0);
    check({tag, "_instret"}, 64'(instret), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_rf_wen = 1'b0; id_opcode = 7'd0; x_redirect = 1'b0; stall_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic flow and latency, including rd=0 writes.
    step(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 7'h03, 1'b0, 1'b0);
    step(1'b1, 5'd7, 5'd5, 5'd3, 1'b1, 7'h33, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd4, 5'd6, 1'b1, 7'h13, 1'b0, 1'b0);
    step(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 7'h23, 1'b0, 1'b0);
    step(1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 7'h33, 1'b0, 1'b0);

    // Redirect resolved in X.
    step(1'b1, 5'd10, 5'd1, 5'd1, 1'b1, 7'h63, 1'b0, 1'b0);
    step(1'b1, 5'd11, 5'd2, 5'd2, 1'b1, 7'h13, 1'b1, 1'b0);
    step(1'b1, 5'd12, 5'd3, 5'd3, 1'b1, 7'h13, 1'b0, 1'b0);
    step(1'b1, 5'd13, 5'd4, 5'd4, 1'b1, 7'h13, 1'b0, 1'b0);
    step(1'b1, 5'd14, 5'd5, 5'd5, 1'b1, 7'h13, 1'b0, 1'b0);

    // Redirect held under a 3-cycle stall, taken on the first free cycle.
    step(1'b1, 5'd15, 5'd6, 5'd6, 1'b1, 7'h6f, 1'b1, 1'b1);
    step(1'b1, 5'd15, 5'd6, 5'd6, 1'b1, 7'h6f, 1'b1, 1'b1);
    step(1'b1, 5'd15, 5'd6, 5'd6, 1'b1, 7'h6f, 1'b1, 1'b1);
    step(1'b1, 5'd15, 5'd6, 5'd6, 1'b1, 7'h6f, 1'b1, 1'b0);
    step(1'b1, 5'd16, 5'd7, 5'd7, 1'b1, 7'h13, 1'b0, 1'b1);
    step(1'b1, 5'd16, 5'd7, 5'd7, 1'b1, 7'h13, 1'b1, 1'b0);
    step(1'b1, 5'd17, 5'd8, 5'd8, 1'b1, 7'h13, 1'b0, 1'b0);
    step(1'b1, 5'd18, 5'd9, 5'd9, 1'b1, 7'h03, 1'b0, 1'b0);

    // Reset asserted mid-flush.
    step(1'b1, 5'd19, 5'd1, 5'd2, 1'b1, 7'h63, 1'b1, 1'b0);
    x_redirect = 1'b0;
    stall_req  = 1'b0;
    id_valid   = 1'b1;
    rst        = 1'b1;
    #1;
    check_all_zero("rst_mid_flush");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 5'd20, 5'd2, 5'd3, 1'b1, 7'h33, 1'b0, 1'b0);
    step(1'b1, 5'd21, 5'd4, 5'd5, 1'b1, 7'h03, 1'b0, 1'b0);
    step(1'b1, 5'd22, 5'd6, 5'd7, 1'b1, 7'h13, 1'b0, 1'b0);

    // Random traffic with stalls and redirects.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1), 7'($urandom_range(0, 127)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
